// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the front-end pipeline and the hazard/stall controller.
// Every signal is a level-sensitive control that is sampled each cycle; there is no valid/ready handshake.
interface hazard_stall_ctrl_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_Branch;
  logic        ID_MulDiv;
  logic        Branch_Taken;
  logic        Jump;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [4:0]  EX_Rd;
  logic        MEM_MemRead;
  logic [4:0]  MEM_Rd;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic [31:0] Stall_Count;
  logic [1:0]  dbg_state;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_MulDiv, Branch_Taken, Jump,
           EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Count, dbg_state
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_MulDiv, Branch_Taken, Jump,
           EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Count, dbg_state
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Front-end hazard/stall controller: load-use, branch-operand and mul/div issue stalls, taken-branch flush.
// Optional stall-cycle counter on Stall_Count is built only when HAZ_STALL_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  logic Clk,
  input  logic Rst,
  hazard_stall_ctrl_if.slave bus
);

  if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_lat_check
    $error("hazard_stall_ctrl: MULDIV_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MD_ISSUE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  state_t     state;
  logic [3:0] cnt;

  logic ex_match;
  logic mem_match;
  logic load_use;
  logic br_haz;
  logic haz;
  logic md_stall;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;

  // Register 0 is hardwired zero, so it never creates a dependency.
  assign ex_match  = (bus.EX_Rd != 5'd0) &&
                     ((bus.EX_Rd == bus.ID_Rs) || (bus.ID_UsesRt && bus.EX_Rd == bus.ID_Rt));
  assign mem_match = (bus.MEM_Rd != 5'd0) &&
                     ((bus.MEM_Rd == bus.ID_Rs) || (bus.ID_UsesRt && bus.MEM_Rd == bus.ID_Rt));

  assign load_use = bus.EX_MemRead && ex_match;
  assign br_haz   = bus.ID_Branch && ((bus.EX_RegWrite && ex_match) || (bus.MEM_MemRead && mem_match));
  assign haz      = load_use || br_haz;
  assign md_stall = (state == MD_BUSY) || (state == RUN && bus.ID_MulDiv);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    // A stall wins over a taken branch: its operands are not valid yet.
    if (Rst || md_stall || haz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (bus.Branch_Taken || bus.Jump) begin
      if_id_flush  = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (bus.ID_MulDiv) begin
            cnt   <= LAT_M1;
            state <= (MULDIV_LAT == 1) ? MD_ISSUE : MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (cnt == 4'd1) state <= MD_ISSUE;
          else             cnt   <= cnt - 4'd1;
        end
        MD_ISSUE: begin
          // The mul/div already served its latency; it only waits for data hazards.
          if (!haz) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt <= 32'd0;
    end else if (!pc_write && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.Stall_Count = stall_cnt;
`else
  assign bus.Stall_Count = 32'd0;
`endif

  assign bus.PC_Write     = pc_write;
  assign bus.IF_ID_Write  = if_id_write;
  assign bus.IF_ID_Flush  = if_id_flush;
  assign bus.ID_EX_Bubble = id_ex_bubble;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (MULDIV_LAT 4 and 1) share stimulus and are checked
// every cycle against a remaining-stall-cycles model, plus directed literal expectations.
module tb_hazard_stall_ctrl;

  logic clk;
  logic rst;

  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rt, id_branch, id_muldiv, br_taken, jump;
  logic       ex_memread, ex_regwrite, mem_memread;

  int checks;
  int failures;

  hazard_stall_ctrl_if if4 ();
  hazard_stall_ctrl_if if1 ();

  assign if4.ID_Rs = id_rs;        assign if1.ID_Rs = id_rs;
  assign if4.ID_Rt = id_rt;        assign if1.ID_Rt = id_rt;
  assign if4.ID_UsesRt = id_uses_rt;   assign if1.ID_UsesRt = id_uses_rt;
  assign if4.ID_Branch = id_branch;    assign if1.ID_Branch = id_branch;
  assign if4.ID_MulDiv = id_muldiv;    assign if1.ID_MulDiv = id_muldiv;
  assign if4.Branch_Taken = br_taken;  assign if1.Branch_Taken = br_taken;
  assign if4.Jump = jump;              assign if1.Jump = jump;
  assign if4.EX_MemRead = ex_memread;  assign if1.EX_MemRead = ex_memread;
  assign if4.EX_RegWrite = ex_regwrite; assign if1.EX_RegWrite = ex_regwrite;
  assign if4.EX_Rd = ex_rd;            assign if1.EX_Rd = ex_rd;
  assign if4.MEM_MemRead = mem_memread; assign if1.MEM_MemRead = mem_memread;
  assign if4.MEM_Rd = mem_rd;          assign if1.MEM_Rd = mem_rd;

  hazard_stall_ctrl #(.MULDIV_LAT(4)) dut4 (.Clk(clk), .Rst(rst), .bus(if4.slave));
  hazard_stall_ctrl #(.MULDIV_LAT(1)) dut1 (.Clk(clk), .Rst(rst), .bus(if1.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: remaining mul/div stall cycles, pending-issue flag, stall counter
  int          lat [2];
  int          md_left [2];
  bit          md_issue [2];
  logic [31:0] m_cnt [2];

  function automatic bit reg_match(input logic [4:0] r);
    return (r != 5'd0) && ((r == id_rs) || (id_uses_rt && r == id_rt));
  endfunction

  function automatic bit data_haz();
    bit lu, bh;
    lu = ex_memread && reg_match(ex_rd);
    bh = id_branch && ((ex_regwrite && reg_match(ex_rd)) || (mem_memread && reg_match(mem_rd)));
    return lu || bh;
  endfunction

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
  function automatic logic [3:0] exp_out(input int k);
    bit md;
    if (rst) return 4'b0001;
    md = (md_left[k] > 0) || (!md_issue[k] && id_muldiv);
    if (md || data_haz())      return 4'b0001;
    if (br_taken || jump)      return 4'b1110;
    return 4'b1100;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md_left[k]  = 0;
      md_issue[k] = 1'b0;
      m_cnt[k]    = 32'd0;
    end
  endtask

  task automatic model_update();
    logic [3:0] o;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        md_left[k] = 0; md_issue[k] = 1'b0; m_cnt[k] = 32'd0;
      end else begin
        o = exp_out(k);
`ifdef HAZ_STALL_CNT_EN
        if (!o[3] && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
`endif
        if (md_left[k] > 0) begin
          md_left[k] = md_left[k] - 1;
          if (md_left[k] == 0) md_issue[k] = 1'b1;
        end else if (md_issue[k]) begin
          if (!data_haz()) md_issue[k] = 1'b0;
        end else if (id_muldiv) begin
          md_left[k] = lat[k] - 1;
          if (md_left[k] == 0) md_issue[k] = 1'b1;
        end
      end
    end
  endtask

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] out4();
    return {if4.PC_Write, if4.IF_ID_Write, if4.IF_ID_Flush, if4.ID_EX_Bubble};
  endfunction

  function automatic logic [3:0] out1();
    return {if1.PC_Write, if1.IF_ID_Write, if1.IF_ID_Flush, if1.ID_EX_Bubble};
  endfunction

  task automatic compare_model();
    if (rst) model_reset();
    chk("lat4_outputs", 32'(out4()), 32'(exp_out(0)));
    chk("lat1_outputs", 32'(out1()), 32'(exp_out(1)));
    chk("lat4_stall_count", if4.Stall_Count, m_cnt[0]);
    chk("lat1_stall_count", if1.Stall_Count, m_cnt[1]);
  endtask

  // driver tasks
  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    id_uses_rt = 1'b0; id_branch = 1'b0; id_muldiv = 1'b0; br_taken = 1'b0; jump = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; mem_memread = 1'b0;
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    id_rs       = 5'($urandom_range(0, 3));
    id_rt       = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    mem_rd      = 5'($urandom_range(0, 3));
    id_uses_rt  = 1'($urandom_range(0, 1));
    id_branch   = ($urandom_range(0, 3) == 0);
    id_muldiv   = ($urandom_range(0, 5) == 0);
    br_taken    = ($urandom_range(0, 3) == 0);
    jump        = ($urandom_range(0, 7) == 0);
    ex_memread  = ($urandom_range(0, 3) == 0);
    ex_regwrite = 1'($urandom_range(0, 1));
    mem_memread = ($urandom_range(0, 3) == 0);
  endtask

  logic [31:0] exp_cnt4;

  initial begin
    checks = 0;
    failures = 0;
    lat[0] = 4;
    lat[1] = 1;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    settle();
    chk("reset_outputs", 32'(out4()), 32'h1);
    chk("reset_count", if4.Stall_Count, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("run_after_reset", 32'(out4()), 32'hC);
    chk("dbg_state_run", 32'(if4.dbg_state), 32'd0);
    tick();

    // load-use, then the same with r0 as destination
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    settle();
    chk("load_use_stall", 32'(out4()), 32'h1);
    tick();
    ex_rd = 5'd0;
    settle();
    chk("load_use_r0", 32'(out4()), 32'hC);
    tick();
    idle_inputs();

    // taken branch without hazard flushes exactly one cycle
    br_taken = 1'b1;
    settle();
    chk("taken_flush", 32'(out4()), 32'hE);
    tick();
    br_taken = 1'b0;
    settle();
    chk("after_flush", 32'(out4()), 32'hC);
    tick();

    // mul/div held high: LAT=4 stalls 4 then advances; LAT=1 stalls 1 then advances
    id_muldiv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("md4_seq", 32'(out4()), (c < 4) ? 32'h1 : 32'hC);
      if (c == 0) chk("md1_stall", 32'(out1()), 32'h1);
      if (c == 1) chk("md1_issue", 32'(out1()), 32'hC);
      tick();
    end
    id_muldiv = 1'b0;
    settle();
    chk("md4_back_to_run", 32'(out4()), 32'hC);
    tick();

`ifdef HAZ_STALL_CNT_EN
    exp_cnt4 = 32'd5;
`else
    exp_cnt4 = 32'd0;
`endif
    chk("stall_count_lat4", if4.Stall_Count, exp_cnt4);

    // branch-operand hazard on rt from a load in MEM blocks the taken-branch flush
    id_branch = 1'b1; mem_memread = 1'b1; mem_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
    br_taken = 1'b1;
    settle();
    chk("br_haz_stall", 32'(out4()), 32'h1);
    tick();
    mem_memread = 1'b0;
    settle();
    chk("br_resolved_flush", 32'(out4()), 32'hE);
    tick();
    idle_inputs();

    // reset asserted in the middle of a mul/div busy phase
    id_muldiv = 1'b1;
    settle();
    tick();
    settle();
    tick();
    rst = 1'b1;
    settle();
    chk("reset_mid_md", 32'(out4()), 32'h1);
    chk("reset_mid_md_count", if4.Stall_Count, 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    chk("run_after_md_reset", 32'(out4()), 32'hC);
    tick();

    // randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      rand_inputs();
      rst = ($urandom_range(0, 99) == 0);
      settle();
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
